// File: rtl/reg_file_wb.sv
// Purpose : ARM architectural register file (R0-R14) fed by the writeback bus; R15 reads give PC+offset, R15 writes redirect fetch.
// Latency : reads are combinational with same-cycle writeback bypass; stored data and the redirect pulse appear one cycle after the write edge.
// Backpressure: none; one writeback is accepted every cycle and reads are always valid.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   i_Sig_Write_Back_Enable         writeback valid this cycle
//   i_Destination / i_Write_Back_Value  writeback index and data
//   i_Pc                            PC of the instruction in decode
//   i_Src_1..3 / o_Reg_1..3         read indices and combinational read data
//   o_Pc_Write_Enable/_Value        registered one-cycle redirect pulse and target
//   o_Valid_Mask                    bit n set once Rn has been written since reset
module reg_file_wb #(
  parameter int DATA_WIDTH     = 32,
  parameter int PC_READ_OFFSET = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Sig_Write_Back_Enable,
  input  logic [3:0]            i_Destination,
  input  logic [DATA_WIDTH-1:0] i_Write_Back_Value,
  input  logic [DATA_WIDTH-1:0] i_Pc,
  input  logic [3:0]            i_Src_1,
  input  logic [3:0]            i_Src_2,
  input  logic [3:0]            i_Src_3,
  output logic [DATA_WIDTH-1:0] o_Reg_1,
  output logic [DATA_WIDTH-1:0] o_Reg_2,
  output logic [DATA_WIDTH-1:0] o_Reg_3,
  output logic                  o_Pc_Write_Enable,
  output logic [DATA_WIDTH-1:0] o_Pc_Write_Value,
  output logic [15:0]           o_Valid_Mask
);

  localparam logic [3:0] PC_IDX = 4'd15;

  logic [DATA_WIDTH-1:0] r_regs [0:14];
  logic [14:0]           r_valid;
  logic                  r_pc_we;
  logic [DATA_WIDTH-1:0] r_pc_val;

  logic [DATA_WIDTH-1:0] w_pc_read;
  logic [3:0]            w_src [0:2];
  logic [DATA_WIDTH-1:0] w_rd  [0:2];
  logic                  w_wr_gpr;

  assign w_pc_read = i_Pc + DATA_WIDTH'(PC_READ_OFFSET);
  assign w_wr_gpr  = i_Sig_Write_Back_Enable && (i_Destination != PC_IDX);

  assign w_src[0] = i_Src_1;
  assign w_src[1] = i_Src_2;
  assign w_src[2] = i_Src_3;

  // R15 has no storage, so it is tested first; this also keeps a writeback
  // to R15 from ever bypassing into an R15 read.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      if (w_src[k] == PC_IDX) begin
        w_rd[k] = w_pc_read;
      end else if (w_wr_gpr && (i_Destination == w_src[k])) begin
        w_rd[k] = i_Write_Back_Value;
      end else begin
        w_rd[k] = r_regs[w_src[k]];
      end
    end
  end

  assign o_Reg_1 = w_rd[0];
  assign o_Reg_2 = w_rd[1];
  assign o_Reg_3 = w_rd[2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= '0;
      end
      r_valid  <= '0;
      r_pc_we  <= 1'b0;
      r_pc_val <= '0;
    end else begin
      // Pulse defaults low; only an R15 writeback raises it for one cycle.
      r_pc_we <= 1'b0;
      if (i_Sig_Write_Back_Enable) begin
        if (i_Destination == PC_IDX) begin
          r_pc_we  <= 1'b1;
          r_pc_val <= i_Write_Back_Value;
        end else begin
          r_regs[i_Destination]  <= i_Write_Back_Value;
          r_valid[i_Destination] <= 1'b1;
        end
      end
    end
  end

  assign o_Pc_Write_Enable = r_pc_we;
  assign o_Pc_Write_Value  = r_pc_val;
  assign o_Valid_Mask      = {1'b0, r_valid};

endmodule

// File: tb/tb_reg_file_wb.sv
// Purpose : self-checking bench for reg_file_wb against a behavioural register-file model.
// Latency : checks combinational reads mid-cycle and registered outputs 1 time unit after each edge.
// Backpressure: not applicable; one stimulus vector per clock.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  dest;
  logic [31:0] wbv;
  logic [31:0] pc;
  logic [3:0]  s1, s2, s3;
  logic [31:0] reg1, reg2, reg3;
  logic        pc_we;
  logic [31:0] pc_val;
  logic [15:0] vmask;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  logic [31:0] m_reg [15];
  logic [15:0] m_mask;
  logic        m_pe;
  logic [31:0] m_pv;
  bit          m_init = 0;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_WIDTH(32), .PC_READ_OFFSET(8)) dut (
    .clk                     (clk),
    .reset                   (rst_n),
    .i_Sig_Write_Back_Enable (en),
    .i_Destination           (dest),
    .i_Write_Back_Value      (wbv),
    .i_Pc                    (pc),
    .i_Src_1                 (s1),
    .i_Src_2                 (s2),
    .i_Src_3                 (s3),
    .o_Reg_1                 (reg1),
    .o_Reg_2                 (reg2),
    .o_Reg_3                 (reg3),
    .o_Pc_Write_Enable       (pc_we),
    .o_Pc_Write_Value        (pc_val),
    .o_Valid_Mask            (vmask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected read value straight from the architectural rules.
  function automatic logic [31:0] model_read(input logic [3:0] s);
    if (s == 4'd15) return pc + 32'd8;
    if (en && dest == s) return wbv;
    return m_reg[s];
  endfunction

  task automatic drive(input logic e, input logic [3:0] d, input logic [31:0] v,
                       input logic [31:0] p, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c);
    en = e; dest = d; wbv = v; pc = p; s1 = a; s2 = b; s3 = c;
    #3;
    if (m_init) begin
      chk("rd1", reg1, model_read(s1));
      chk("rd2", reg2, model_read(s2));
      chk("rd3", reg3, model_read(s3));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) m_reg[i] = '0;
      m_mask = '0;
      m_pe   = 1'b0;
      m_pv   = '0;
      m_init = 1;
    end else begin
      m_pe = 1'b0;
      if (en) begin
        if (dest == 4'd15) begin
          m_pe = 1'b1;
          m_pv = wbv;
        end else begin
          m_reg[dest] = wbv;
          m_mask[dest] = 1'b1;
        end
      end
    end
    #1;
    chk("pc_we",  {31'd0, pc_we}, {31'd0, m_pe});
    chk("pc_val", pc_val, m_pv);
    chk("vmask",  {16'd0, vmask}, {16'd0, m_mask});
  endtask

  task automatic sweep(input logic [31:0] p);
    for (int r = 0; r < 15; r += 3)
      begin
        drive(1'b0, 4'd0, 32'd0, p, 4'(r), 4'(r + 1), 4'(r + 2));
        tick();
      end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; dest = 0; wbv = 0; pc = 0; s1 = 0; s2 = 0; s3 = 0;
    @(posedge clk); #1;

    // Reset held 2 cycles with a competing write to R4
    drive(1'b1, 4'd4, 32'hDEADBEEF, 32'h0, 4'd4, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd4, 32'hDEADBEEF, 32'h0, 4'd4, 4'd0, 4'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 4'd4, 32'hDEADBEEF, 32'h0, 4'd4, 4'd4, 4'd4);
    chk("reset_r4",    reg1, 32'h0);
    chk("reset_mask",  {16'd0, vmask}, 32'h0);
    chk("reset_pc_we", {31'd0, pc_we}, 32'h0);
    tick();

    // Basic write then read
    drive(1'b1, 4'd1, 32'hABCD1234, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 4'd1, 4'd0, 4'd0);
    chk("basic_r1",   reg1, 32'hABCD1234);
    chk("basic_mask", {16'd0, vmask}, 32'h0000_0002);
    tick();

    // Same-cycle bypass on two ports
    drive(1'b1, 4'd2, 32'h55667788, 32'h0, 4'd0, 4'd2, 4'd2);
    chk("bypass_r2", reg2, 32'h55667788);
    chk("bypass_r3", reg3, 32'h55667788);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 4'd2, 4'd0, 4'd0);
    chk("stored_r2", reg1, 32'h55667788);
    tick();

    // Disabled write leaves R3 alone
    drive(1'b0, 4'd3, 32'hAABBCCDD, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b0, 4'd3, 32'hAABBCCDD, 32'h0, 4'd3, 4'd0, 4'd0);
    chk("disabled_r3",   reg1, 32'h0);
    chk("disabled_mask", {31'd0, vmask[3]}, 32'h0);
    tick();

    // R15 reads, including wrap, and no bypass onto R15
    drive(1'b0, 4'd0, 32'h0, 32'h00001000, 4'd15, 4'd15, 4'd1);
    chk("r15_read", reg1, 32'h00001008);
    tick();
    drive(1'b1, 4'd15, 32'h12345678, 32'hFFFFFFFC, 4'd15, 4'd0, 4'd0);
    chk("r15_wrap", reg1, 32'h00000004);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();

    // Single R15 write: one-cycle pulse, value held
    drive(1'b1, 4'd15, 32'h00002000, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();
    chk("redir_we",  {31'd0, pc_we}, 32'h1);
    chk("redir_val", pc_val, 32'h00002000);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();
    chk("redir_drop", {31'd0, pc_we}, 32'h0);
    chk("redir_hold", pc_val, 32'h00002000);
    chk("redir_mask15", {31'd0, vmask[15]}, 32'h0);
    sweep(32'h0);

    // Back-to-back R15 writes
    drive(1'b1, 4'd15, 32'h00003000, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd15, 32'h00004000, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();
    chk("b2b_val", pc_val, 32'h00004000);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();

    // Consecutive writes to one register: newest wins
    drive(1'b1, 4'd7, 32'h11111111, 32'h0, 4'd7, 4'd7, 4'd0);
    tick();
    drive(1'b1, 4'd7, 32'h22222222, 32'h0, 4'd7, 4'd0, 4'd0);
    chk("newest_bypass", reg1, 32'h22222222);
    tick();
    drive(1'b0, 4'd0, 32'h0, 32'h0, 4'd7, 4'd0, 4'd0);
    chk("newest_stored", reg1, 32'h22222222);
    tick();

    // R15 write followed by reset: pulse suppressed, concurrent write dropped
    drive(1'b1, 4'd15, 32'h00005000, 32'h0, 4'd0, 4'd0, 4'd0);
    rst_n = 1'b0;
    tick();
    chk("rst_suppress", {31'd0, pc_we}, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 32'h0, 4'd7, 4'd1, 4'd2);
    tick();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(), $urandom(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
    end
    rst_n = 1'b1;
    sweep($urandom());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
